systolic_skew_feeder: RTL and testbench

Upstream edge feeder for the systolic MAC array. Accepts one ROWS-wide activation vector per handshake and frames each vector burst as a tile. Injects the tile into the array's left edge with diagonal skew: row i is delayed i extra cycles. Drives per-row data/valid/sync so each edge PE accumulates exactly one tile, holds psum between tiles, and clears psum before the next tile.

---
 rtl/tc_pkg.sv | 26 ++
 rtl/skew_delay_line.sv | 40 ++++
 rtl/systolic_skew_feeder.sv | 133 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types for the systolic edge feeder: lane token, FSM states and
// the fixed tokens injected at the head of every skew lane.
package tc_pkg;

    localparam int TC_ROWS   = 4;
    localparam int TC_DATA_W = 8;

    typedef struct packed {
        logic signed [TC_DATA_W-1:0] data;
        logic                        valid;
        logic                        sync;
    } lane_tok_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN
    } fsm_state_t;

    // Idle/bubble token: PE holds its psum.
    localparam lane_tok_t IDLE_TOK  = '{data: '0, valid: 1'b0, sync: 1'b1};
    // Clear token: PE drops its psum ahead of the first beat of a tile.
    localparam lane_tok_t CLEAR_TOK = '{data: '0, valid: 1'b0, sync: 1'b0};

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain carrying one lane token. Valid/sync always
// shift; a data register only loads when the token entering it is valid.
module skew_delay_line
    import tc_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    input  lane_tok_t tok_in,
    output lane_tok_t tok_out
);

    lane_tok_t stage_q [DEPTH];
    lane_tok_t stage_d [DEPTH];

    always_comb begin
        stage_d[0].valid = tok_in.valid;
        stage_d[0].sync  = tok_in.sync;
        stage_d[0].data  = tok_in.valid ? tok_in.data : stage_q[0].data;
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k].valid = stage_q[k-1].valid;
            stage_d[k].sync  = stage_q[k-1].sync;
            stage_d[k].data  = stage_q[k-1].valid ? stage_q[k-1].data : stage_q[k].data;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (!reset_n) begin
                stage_q[k] <= IDLE_TOK;
            end else begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign tok_out = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Frames upstream activation vectors into tiles and injects them into the
// array's left edge with a diagonal skew (row i delayed i extra cycles).
//
// state  | meaning
// IDLE   | no tile; waits for in_valid
// CLEAR  | one cycle; sends the psum-clear token down every lane
// STREAM | accepts beats; gaps become hold bubbles
// DRAIN  | ROWS cycles letting the last beat reach row ROWS-1
module systolic_skew_feeder
    import tc_pkg::*;
#(
    parameter int ROWS   = TC_ROWS,
    parameter int DATA_W = TC_DATA_W,
    parameter int K_MAX  = 16,
    parameter int CNT_W  = $clog2(K_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_data,
    input  logic                   in_last,
    output logic [ROWS*DATA_W-1:0] acc_data,
    output logic [ROWS-1:0]        acc_data_valid,
    output logic [ROWS-1:0]        counter_sync,
    output logic                   busy,
    output logic                   tile_done,
    output logic [CNT_W-1:0]       beat_cnt,
    output logic                   forced_last
);

    localparam int DR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    fsm_state_t       state_q,       state_d;
    logic [CNT_W-1:0] beat_cnt_q,    beat_cnt_d;
    logic [DR_W-1:0]  drain_cnt_q,   drain_cnt_d;
    logic             forced_last_q, forced_last_d;
    logic             tile_done_q,   tile_done_d;
    logic             xfer;
    lane_tok_t        head_tok [ROWS];

    assign xfer = in_valid && (state_q == ST_STREAM);

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        forced_last_d = forced_last_q;
        tile_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (in_last || (beat_cnt_q == CNT_W'(K_MAX - 1))) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                        if (!in_last) forced_last_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Pulse lands the cycle after the last beat has left row ROWS-1.
                if (drain_cnt_q == DR_W'(ROWS - 1)) begin
                    state_d     = ST_IDLE;
                    beat_cnt_d  = '0;
                    tile_done_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            forced_last_q <= 1'b0;
            tile_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            forced_last_q <= forced_last_d;
            tile_done_q   <= tile_done_d;
        end
    end

    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            head_tok[i] = IDLE_TOK;
            if (state_q == ST_CLEAR) begin
                head_tok[i] = CLEAR_TOK;
            end else if (xfer) begin
                head_tok[i].data  = in_data[i*DATA_W +: DATA_W];
                head_tok[i].valid = 1'b1;
                head_tok[i].sync  = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        lane_tok_t row_tok;

        skew_delay_line #(
            .DEPTH(i + 1)
        ) u_dly (
            .clk    (clk),
            .reset_n(reset_n),
            .tok_in (head_tok[i]),
            .tok_out(row_tok)
        );

        assign acc_data[i*DATA_W +: DATA_W] = row_tok.data;
        assign acc_data_valid[i]            = row_tok.valid;
        assign counter_sync[i]              = row_tok.sync;
    end

    assign in_ready    = (state_q == ST_STREAM);
    assign busy        = (state_q != ST_IDLE);
    assign tile_done   = tile_done_q;
    assign beat_cnt    = beat_cnt_q;
    assign forced_last = forced_last_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a per-cycle token history model predicts
// every output; directed tiles pin the model with hand-derived literals.
module tb_systolic_skew_feeder;

    localparam int ROWS = 4;
    localparam int DW   = 8;
    localparam int KM   = 4;
    localparam int CW   = $clog2(KM + 1);
    localparam int MAXP = 8192;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 in_last;
    logic [ROWS*DW-1:0]   acc_data;
    logic [ROWS-1:0]      acc_data_valid;
    logic [ROWS-1:0]      counter_sync;
    logic                 busy;
    logic                 tile_done;
    logic [CW-1:0]        beat_cnt;
    logic                 forced_last;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .ROWS(ROWS), .DATA_W(DW), .K_MAX(KM), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .acc_data(acc_data),
        .acc_data_valid(acc_data_valid), .counter_sync(counter_sync),
        .busy(busy), .tile_done(tile_done), .beat_cnt(beat_cnt),
        .forced_last(forced_last)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 idle, 1 clear, 2 stream, 3 drain. tv/ts/tdat record the token
    // entering the skew at each clock edge; row i shows edge (p - i).
    int  p = 0;
    int  last_rst = -1000;
    bit  rst_seen = 0;
    int  m_phase = 0, m_beats = 0, m_drain = 0, m_last_xfer_p = -1;
    bit  m_forced = 0, m_done = 0, m_xfer = 0;
    bit  tv [MAXP];
    bit  ts [MAXP];
    logic [ROWS*DW-1:0] tdat [MAXP];

    always @(posedge clk) begin
        p = p + 1;
        if (p >= MAXP - 1) begin
            $display("FAIL history_overflow: got %0d cycles, expected fewer than %0d", p, MAXP);
            $fatal(1);
        end
        m_xfer  = 0;
        m_done  = 0;
        tv[p]   = 0;
        ts[p]   = 1;
        tdat[p] = '0;
        if (!reset_n) begin
            m_phase  = 0;
            m_beats  = 0;
            m_drain  = 0;
            m_forced = 0;
            last_rst = p;
            rst_seen = 1;
        end else begin
            case (m_phase)
                0: if (in_valid) m_phase = 1;
                1: begin ts[p] = 0; m_phase = 2; end
                2: if (in_valid) begin
                    m_xfer = 1; m_last_xfer_p = p;
                    tv[p] = 1; tdat[p] = in_data;
                    m_beats++;
                    if (in_last || m_beats == KM) begin
                        if (!in_last) m_forced = 1;
                        m_phase = 3; m_drain = 0;
                    end
                end
                default: begin
                    m_drain++;
                    if (m_drain == ROWS) begin m_phase = 0; m_beats = 0; m_done = 1; end
                end
            endcase
        end
    end

    function automatic logic [DW-1:0] exp_data(input int lane, input int idx);
        for (int q = idx; q > last_rst; q--)
            if (tv[q]) return tdat[q][lane*DW +: DW];
        return '0;
    endfunction

    // ---------------- logs used by literal checks ----------------
    logic [DW-1:0] q_r0[$], q_r3[$], q_d0[$];
    bit            q_v0[$], q_s0[$];
    int first_v0, first_v3, sync0_r0, sync0_cnt_r3, td_cnt, td_p;

    task automatic clear_logs();
        q_r0.delete(); q_r3.delete(); q_d0.delete(); q_v0.delete(); q_s0.delete();
        first_v0 = -1; first_v3 = -1; sync0_r0 = -1; sync0_cnt_r3 = 0; td_cnt = 0; td_p = -1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_seen) begin
            chk("in_ready", in_ready, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            chk("tile_done", tile_done, m_done);
            chk("beat_cnt", beat_cnt, m_beats);
            chk("forced_last", forced_last, m_forced);
            for (int i = 0; i < ROWS; i++) begin
                int idx;
                logic ev, es;
                logic [DW-1:0] ed;
                idx = p - i;
                if (idx <= last_rst) begin
                    ev = 0; es = 1; ed = '0;
                end else begin
                    ev = tv[idx]; es = ts[idx]; ed = exp_data(i, idx);
                end
                chk($sformatf("row%0d {valid,sync,data}", i),
                    {acc_data_valid[i], counter_sync[i], acc_data[i*DW +: DW]}, {ev, es, ed});
            end
            if (acc_data_valid[0]) q_r0.push_back(acc_data[DW-1:0]);
            if (acc_data_valid[3]) q_r3.push_back(acc_data[3*DW +: DW]);
            if (first_v0 < 0 && acc_data_valid[0]) first_v0 = p;
            if (first_v3 < 0 && acc_data_valid[3]) first_v3 = p;
            if (first_v0 >= 0 && q_v0.size() < 4) begin
                q_v0.push_back(acc_data_valid[0]);
                q_d0.push_back(acc_data[DW-1:0]);
                q_s0.push_back(counter_sync[0]);
            end
            if (!counter_sync[0]) sync0_r0 = p;
            if (!counter_sync[3]) sync0_cnt_r3++;
            if (tile_done) begin td_cnt++; td_p = p; end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [ROWS*DW-1:0] vec(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic cyc(input bit v, input bit last, input logic [ROWS*DW-1:0] d);
        @(negedge clk);
        in_valid = v; in_last = last; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, '0);
    endtask

    task automatic send(input logic [ROWS*DW-1:0] d, input bit last);
        int n;
        n = 0;
        do begin
            cyc(1, last, d);
            n++;
        end while (!m_xfer && n < 40);
        if (!m_xfer) chk("send_timeout", m_xfer, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 0; in_valid = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic run_s1(input string tag);
        int lx;
        logic [7:0] e0 [3];
        logic [7:0] e3 [3];
        e0 = '{8'd1, 8'd5, 8'd9};
        e3 = '{8'd4, 8'd8, 8'd12};
        clear_logs();
        send(vec(1, 2, 3, 4), 0);
        send(vec(5, 6, 7, 8), 0);
        send(vec(9, 10, 11, 12), 1);
        lx = m_last_xfer_p;
        idle(10);
        chk({tag, "_r0_count"}, q_r0.size(), 3);
        chk({tag, "_r3_count"}, q_r3.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_r0_beat%0d", tag, k), q_r0[k], e0[k]);
            chk($sformatf("%s_r3_beat%0d", tag, k), q_r3[k], e3[k]);
        end
        chk({tag, "_r3_skew"}, first_v3 - first_v0, 3);
        chk({tag, "_r0_clear_before_first"}, sync0_r0, first_v0 - 1);
        chk({tag, "_done_count"}, td_cnt, 1);
        chk({tag, "_done_after_drain_entry"}, td_p - lx, 4);
    endtask

    int x4, x5;

    initial begin
        reset_n = 0; in_valid = 0; in_last = 0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        idle(3);

        run_s1("s1");

        // bubble between beats 1 and 2
        clear_logs();
        send(vec(1, 2, 3, 4), 0);
        cyc(0, 0, '0);
        send(vec(5, 6, 7, 8), 0);
        send(vec(9, 10, 11, 12), 1);
        idle(10);
        chk("s2_r0_seq_valid", {q_v0[0], q_v0[1], q_v0[2], q_v0[3]}, 4'b1011);
        chk("s2_r0_seq_sync", {q_s0[0], q_s0[1], q_s0[2], q_s0[3]}, 4'b1111);
        chk("s2_r0_seq_data", {q_d0[0], q_d0[1], q_d0[2], q_d0[3]}, {8'd1, 8'd1, 8'd5, 8'd9});
        chk("s2_forced_clear", forced_last, 0);

        // K_MAX force-termination
        clear_logs();
        send(vec(21, 22, 23, 24), 0);
        send(vec(25, 26, 27, 28), 0);
        send(vec(29, 30, 31, 32), 0);
        send(vec(33, 34, 35, 36), 0);
        x4 = m_last_xfer_p;
        chk("s3_forced_set", forced_last, 1);
        send(vec(37, 38, 39, 40), 0);
        x5 = m_last_xfer_p;
        chk("s3_gap", x5 - x4, 7);
        chk("s3_fifth_is_first", beat_cnt, 1);
        chk("s3_done_count", td_cnt, 1);
        send(vec(41, 42, 43, 44), 1);
        idle(10);
        chk("s3_forced_sticky", forced_last, 1);

        // back-to-back tiles, in_valid held
        clear_logs();
        send(vec(51, 52, 53, 54), 0);
        send(vec(55, 56, 57, 58), 1);
        send(vec(61, 62, 63, 64), 0);
        chk("s4_beat_restart", beat_cnt, 1);
        send(vec(65, 66, 67, 68), 1);
        idle(10);
        chk("s4_r3_one_clear_per_tile", sync0_cnt_r3, 2);
        chk("s4_done_count", td_cnt, 2);

        // reset mid-STREAM
        clear_logs();
        send(vec(71, 72, 73, 74), 0);
        send(vec(75, 76, 77, 78), 0);
        @(negedge clk);
        reset_n = 0; in_valid = 0;
        @(posedge clk);
        #1;
        chk("s5_busy", busy, 0);
        chk("s5_in_ready", in_ready, 0);
        chk("s5_valid", acc_data_valid, 4'h0);
        chk("s5_sync", counter_sync, 4'hF);
        chk("s5_data", acc_data, 32'h0);
        chk("s5_beat_cnt", beat_cnt, 0);
        chk("s5_forced", forced_last, 0);
        @(negedge clk);
        reset_n = 1;
        idle(8);
        chk("s5_no_done", td_cnt, 0);
        run_s1("s5_fresh");

        // negative data
        clear_logs();
        send(vec(8'h80, 8'h7F, 8'hFF, 8'h80), 1);
        idle(8);
        chk("s6_r0_neg", q_r0[0], 8'h80);
        chk("s6_r3_neg", q_r3[0], 8'h80);
        chk("s6_skew", first_v3 - first_v0, 3);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send($urandom, $urandom_range(0, 3) == 0);
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
